// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register file widths and the queued write record
package regfile_pkg;

  localparam int ADDR_WIDTH = 3;
  localparam int DATA_WIDTH = 8;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/write_queue.sv
// rtl/write_queue.sv - per-requester FIFO of pending register writes
module write_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                              clock,
  input  logic                              resetN,
  input  logic                              pushValid,
  output logic                              pushReady,
  input  wr_req_t                           pushReq,
  input  logic                              popEn,
  output logic                              headValid,
  output wr_req_t                           headReq,
  output logic [DEPTH-1:0]                  entryValid,
  output logic [DEPTH-1:0][ADDR_WIDTH-1:0]  entryAddr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wr_req_t          mem [DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Ready comes only from the registered count, so a full queue never passes through.
  assign pushReady = resetN && (count != CNT_W'(DEPTH));
  assign headValid = (count != '0);
  assign headReq   = mem[headPtr];
  assign push      = pushValid && pushReady;
  assign pop       = popEn && headValid;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (push) tailPtr <= nextPtr(tailPtr);
      if (pop)  headPtr <= nextPtr(headPtr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[tailPtr] <= pushReq;
  end

  // Slot i is live when its distance from the head is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entryValid[i] = ((i - int'(headPtr) + DEPTH) % DEPTH) < int'(count);
      entryAddr[i]  = mem[i].addr;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin sharing of the register file write port
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = regfile_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH  = regfile_pkg::DATA_WIDTH,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic [NUM_REQ-1:0]            reqValid,
  output logic [NUM_REQ-1:0]            reqReady,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] reqAddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
  output logic                          regWrite,
  output logic [ADDR_WIDTH-1:0]         writeRegister,
  output logic [DATA_WIDTH-1:0]         writeData,
  output logic [2**ADDR_WIDTH-1:0]      pendingMask,
  output logic                          idle
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                        headValid;
  logic [NUM_REQ-1:0]                        popEn;
  wr_req_t                                   pushReq   [NUM_REQ];
  wr_req_t                                   headReq   [NUM_REQ];
  logic [QUEUE_DEPTH-1:0]                    entryValid[NUM_REQ];
  logic [QUEUE_DEPTH-1:0][ADDR_WIDTH-1:0]    entryAddr [NUM_REQ];
  logic [RR_W-1:0]                           rrPtr;
  logic [RR_W-1:0]                           winner;
  logic [RR_W-1:0]                           scanIdx;
  logic                                      grantValid;

  for (genvar i = 0; i < NUM_REQ; i++) begin : gQueue
    assign pushReq[i] = {reqAddr[i*ADDR_WIDTH +: ADDR_WIDTH], reqData[i*DATA_WIDTH +: DATA_WIDTH]};

    write_queue #(.DEPTH(QUEUE_DEPTH)) uQueue (
      .clock      (clock),
      .resetN     (resetN),
      .pushValid  (reqValid[i]),
      .pushReady  (reqReady[i]),
      .pushReq    (pushReq[i]),
      .popEn      (popEn[i]),
      .headValid  (headValid[i]),
      .headReq    (headReq[i]),
      .entryValid (entryValid[i]),
      .entryAddr  (entryAddr[i])
    );
  end

  // First non-empty head at or after rrPtr, wrapping, wins.
  always_comb begin
    grantValid = 1'b0;
    winner     = '0;
    scanIdx    = '0;
    popEn      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scanIdx = RR_W'((int'(rrPtr) + k) % NUM_REQ);
      if (!grantValid && headValid[scanIdx]) begin
        grantValid = 1'b1;
        winner     = scanIdx;
      end
    end
    if (grantValid) popEn[winner] = 1'b1;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rrPtr         <= '0;
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
    end else if (grantValid) begin
      regWrite      <= 1'b1;
      writeRegister <= headReq[winner].addr;
      writeData     <= headReq[winner].data;
      rrPtr         <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end else begin
      regWrite <= 1'b0;
    end
  end

  always_comb begin
    pendingMask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < QUEUE_DEPTH; j++) begin
        if (entryValid[i][j]) pendingMask[entryAddr[i][j]] = 1'b1;
      end
    end
    if (regWrite) pendingMask[writeRegister] = 1'b1;
  end

  assign idle = !(|headValid) && !regWrite;

endmodule
